// File: rtl/i2cs_pkg.sv
// Shared constants for the I2C-slave mailbox register block: register
// addresses, STATUS bit positions and a helper that assembles STATUS.
package i2cs_pkg;

    // Register map
    localparam logic [7:0] ADDR_ID           = 8'h00;
    localparam logic [7:0] ADDR_DEBOUNCE_LEN = 8'h01;
    localparam logic [7:0] ADDR_SCL_DELAY    = 8'h02;
    localparam logic [7:0] ADDR_SDA_DELAY    = 8'h03;
    localparam logic [7:0] ADDR_SCRATCH      = 8'h04;
    localparam logic [7:0] ADDR_I2H_DATA     = 8'h10;
    localparam logic [7:0] ADDR_H2I_DATA     = 8'h11;
    localparam logic [7:0] ADDR_STATUS       = 8'h12;
    localparam logic [7:0] ADDR_I2H_COUNT    = 8'h13;
    localparam logic [7:0] ADDR_H2I_COUNT    = 8'h14;

    // STATUS bit positions
    localparam int STS_I2H_FULL      = 0;
    localparam int STS_I2H_EMPTY     = 1;
    localparam int STS_H2I_FULL      = 2;
    localparam int STS_H2I_EMPTY     = 3;
    localparam int STS_I2H_OVERFLOW  = 4;
    localparam int STS_H2I_UNDERFLOW = 5;

    // Assemble the STATUS byte; bits [7:6] always read 0.
    function automatic logic [7:0] build_status(
        input logic i2h_full,
        input logic i2h_empty,
        input logic h2i_full,
        input logic h2i_empty,
        input logic i2h_overflow,
        input logic h2i_underflow
    );
        logic [7:0] s;
        s                    = 8'h00;
        s[STS_I2H_FULL]      = i2h_full;
        s[STS_I2H_EMPTY]     = i2h_empty;
        s[STS_H2I_FULL]      = h2i_full;
        s[STS_H2I_EMPTY]     = h2i_empty;
        s[STS_I2H_OVERFLOW]  = i2h_overflow;
        s[STS_H2I_UNDERFLOW] = h2i_underflow;
        return s;
    endfunction

endpackage

// File: rtl/i2cs_sync_fifo.sv
// Single-clock FIFO used by both mailbox directions. A push is accepted only
// when the FIFO is not full at that edge (a same-cycle pop does not make room),
// a pop only when it is not empty. The head reads 0 while empty.
module i2cs_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/i2cs_mailbox_regs.sv
// I2C-slave register block: ID, timing lengths, scratch, and two mailboxes
// (I2C-to-host and host-to-I2C) with status, counts and sticky error flags.
//
// Host ports use valid/ready: a byte moves on a rising edge where valid and
// ready are both high; valid never depends on ready within this block.
module i2cs_mailbox_regs
    import i2cs_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] ID_VALUE   = 8'hA5,
    parameter logic [7:0] LEN_RST    = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i2c_reg_addr_i,
    input  logic [7:0] i2c_reg_wdata_i,
    input  logic       i2c_reg_wrenable_i,
    output logic [7:0] i2c_reg_rddata_o,
    input  logic       i2c_reg_rd_byte_complete_i,
    output logic [7:0] i2c_debounce_len_o,
    output logic [7:0] i2c_scl_delay_len_o,
    output logic [7:0] i2c_sda_delay_len_o,
    input  logic [7:0] h2i_data_i,
    input  logic       h2i_valid_i,
    output logic       h2i_ready_o,
    output logic [7:0] i2h_data_o,
    output logic       i2h_valid_o,
    input  logic       i2h_ready_i
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    debounce_len;
    logic [7:0]    scl_delay_len;
    logic [7:0]    sda_delay_len;
    logic [7:0]    scratch;
    logic          i2h_overflow;
    logic          h2i_underflow;

    logic          i2h_full, i2h_empty, h2i_full, h2i_empty;
    logic [CW-1:0] i2h_count, h2i_count;
    logic [7:0]    i2h_head, h2i_head;

    logic          wr_i2h, wr_status, rd_done_h2i;
    logic          ovf_set, unf_set;
    logic [7:0]    status;

    assign wr_i2h      = i2c_reg_wrenable_i && (i2c_reg_addr_i == ADDR_I2H_DATA);
    assign wr_status   = i2c_reg_wrenable_i && (i2c_reg_addr_i == ADDR_STATUS);
    assign rd_done_h2i = i2c_reg_rd_byte_complete_i && (i2c_reg_addr_i == ADDR_H2I_DATA);
    assign ovf_set     = wr_i2h && i2h_full;
    assign unf_set     = rd_done_h2i && h2i_empty;

    i2cs_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_i2h_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_i2h),
        .wdata (i2c_reg_wdata_i),
        .pop   (i2h_ready_i),
        .full  (i2h_full),
        .empty (i2h_empty),
        .count (i2h_count),
        .head  (i2h_head)
    );

    i2cs_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_h2i_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (h2i_valid_i),
        .wdata (h2i_data_i),
        .pop   (rd_done_h2i),
        .full  (h2i_full),
        .empty (h2i_empty),
        .count (h2i_count),
        .head  (h2i_head)
    );

    assign h2i_ready_o = !h2i_full;
    assign i2h_valid_o = !i2h_empty;
    assign i2h_data_o  = i2h_head;

    assign i2c_debounce_len_o  = debounce_len;
    assign i2c_scl_delay_len_o = scl_delay_len;
    assign i2c_sda_delay_len_o = sda_delay_len;

    // Read/write configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debounce_len  <= LEN_RST;
            scl_delay_len <= LEN_RST;
            sda_delay_len <= LEN_RST;
            scratch       <= 8'h00;
        end else if (i2c_reg_wrenable_i) begin
            case (i2c_reg_addr_i)
                ADDR_DEBOUNCE_LEN: debounce_len  <= i2c_reg_wdata_i;
                ADDR_SCL_DELAY:    scl_delay_len <= i2c_reg_wdata_i;
                ADDR_SDA_DELAY:    sda_delay_len <= i2c_reg_wdata_i;
                ADDR_SCRATCH:      scratch       <= i2c_reg_wdata_i;
                default: ;
            endcase
        end
    end

    // Sticky error flags: a set event outranks a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i2h_overflow  <= 1'b0;
            h2i_underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                i2h_overflow <= 1'b1;
            end else if (wr_status && i2c_reg_wdata_i[STS_I2H_OVERFLOW]) begin
                i2h_overflow <= 1'b0;
            end
            if (unf_set) begin
                h2i_underflow <= 1'b1;
            end else if (wr_status && i2c_reg_wdata_i[STS_H2I_UNDERFLOW]) begin
                h2i_underflow <= 1'b0;
            end
        end
    end

    assign status = build_status(i2h_full, i2h_empty, h2i_full, h2i_empty,
                                 i2h_overflow, h2i_underflow);

    // Combinational read mux; unmapped and write-only addresses read 0.
    always_comb begin
        i2c_reg_rddata_o = 8'h00;
        case (i2c_reg_addr_i)
            ADDR_ID:           i2c_reg_rddata_o = ID_VALUE;
            ADDR_DEBOUNCE_LEN: i2c_reg_rddata_o = debounce_len;
            ADDR_SCL_DELAY:    i2c_reg_rddata_o = scl_delay_len;
            ADDR_SDA_DELAY:    i2c_reg_rddata_o = sda_delay_len;
            ADDR_SCRATCH:      i2c_reg_rddata_o = scratch;
            ADDR_H2I_DATA:     i2c_reg_rddata_o = h2i_head;
            ADDR_STATUS:       i2c_reg_rddata_o = status;
            ADDR_I2H_COUNT:    i2c_reg_rddata_o = {{(8-CW){1'b0}}, i2h_count};
            ADDR_H2I_COUNT:    i2c_reg_rddata_o = {{(8-CW){1'b0}}, h2i_count};
            default:           i2c_reg_rddata_o = 8'h00;
        endcase
    end

endmodule
